// File: rtl/pixel_pkg.sv
// pixel_pkg: shared widths and storage types for the pixel reorder buffer.
//   COLOUR_W / COORD_W : default colour and coordinate widths
//   pixel_t            : one pixel {x, y, colour}
//   slot_t             : one buffer slot {valid, pixel}
package pixel_pkg;

    localparam int COLOUR_W = 24;
    localparam int COORD_W  = 10;

    typedef struct packed {
        logic [COORD_W-1:0]  x;
        logic [COORD_W-1:0]  y;
        logic [COLOUR_W-1:0] colour;
    } pixel_t;

    typedef struct packed {
        logic   valid;
        pixel_t pix;
    } slot_t;

endpackage

// File: rtl/pixel_reorder_buffer_rr_arbiter.sv
// rr_arbiter: combinational round-robin arbiter.
//   req       : request vector, one bit per requester
//   ptr       : index where the search starts (highest priority)
//   grant     : one-hot grant, all zero when nothing requests
//   grant_idx : index of the granted requester (0 when none)
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx
);

    logic             found;
    logic [IDX_W-1:0] idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = '0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = IDX_W'((32'(ptr) + k) % N);
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/pixel_reorder_buffer.sv
// pixel_reorder_buffer: collects pixels finished out of order by N_CH render
// engines in a DEPTH-slot associative buffer and emits them in raster order.
//   clk, reset            : clock, synchronous active-high reset
//   in_valid/in_ready     : per-channel handshake; one channel accepted per cycle
//   in_colour/in_x/in_y   : packed per-channel pixel data (channel i at [i*W +: W])
//   out_valid/out_ready   : output stream handshake
//   out_colour            : emitted pixel colour
//   out_sof / out_eol     : pixel is (0,0) / pixel is last of its line
//   occupancy / full      : number of valid slots / all slots valid
//   dup_drop              : one-cycle pulse when an accepted pixel is discarded
//   deadlock              : sticky; buffer full with no emittable pixel for 2 cycles
module pixel_reorder_buffer #(
    parameter int N_CH     = 4,
    parameter int DEPTH    = 16,
    parameter int COLOUR_W = pixel_pkg::COLOUR_W,
    parameter int COORD_W  = pixel_pkg::COORD_W,
    parameter int IMG_W    = 640,
    parameter int IMG_H    = 480
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [N_CH-1:0]              in_valid,
    output logic [N_CH-1:0]              in_ready,
    input  logic [N_CH*COLOUR_W-1:0]     in_colour,
    input  logic [N_CH*COORD_W-1:0]      in_x,
    input  logic [N_CH*COORD_W-1:0]      in_y,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [COLOUR_W-1:0]          out_colour,
    output logic                         out_sof,
    output logic                         out_eol,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy,
    output logic                         full,
    output logic                         dup_drop,
    output logic                         deadlock
);

    import pixel_pkg::pixel_t;
    import pixel_pkg::slot_t;

    localparam int OCC_W  = $clog2(DEPTH + 1);
    localparam int SLOT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PTR_W  = (N_CH > 1) ? $clog2(N_CH) : 1;

    localparam logic [31:0]        W_LIM  = 32'(IMG_W);
    localparam logic [31:0]        H_LIM  = 32'(IMG_H);
    localparam logic [COORD_W-1:0] X_LAST = COORD_W'(IMG_W - 1);
    localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(IMG_H - 1);

    slot_t               slots [DEPTH];
    logic [COORD_W-1:0]  exp_x;
    logic [COORD_W-1:0]  exp_y;
    logic [PTR_W-1:0]    ptr;
    logic                stall_d;

    logic [N_CH-1:0]     grant;
    logic [PTR_W-1:0]    grant_idx;
    logic                xfer;
    pixel_t              in_pix;

    logic                free_found;
    logic [SLOT_W-1:0]   free_idx;
    logic                dup_hit;
    logic                out_of_range;
    logic                drop;
    logic                wr;

    logic                match_found;
    logic [SLOT_W-1:0]   match_idx;
    logic                load;
    logic [OCC_W-1:0]    occ_next;

    rr_arbiter #(
        .N     (N_CH),
        .IDX_W (PTR_W)
    ) u_arb (
        .req       (in_valid),
        .ptr       (ptr),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign in_ready = full ? '0 : grant;
    assign xfer     = |(in_valid & in_ready);

    always_comb begin
        in_pix = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (grant[i]) begin
                in_pix.x      = in_x[i*COORD_W +: COORD_W];
                in_pix.y      = in_y[i*COORD_W +: COORD_W];
                in_pix.colour = in_colour[i*COLOUR_W +: COLOUR_W];
            end
        end
    end

    // All slot searches look at the state at the start of the cycle, so a
    // slot freed by this cycle's load is not a write target until next cycle
    // and a pixel written this cycle cannot match until next cycle.
    always_comb begin
        free_found  = 1'b0;
        free_idx    = '0;
        dup_hit     = 1'b0;
        match_found = 1'b0;
        match_idx   = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (!slots[i].valid && !free_found) begin
                free_found = 1'b1;
                free_idx   = SLOT_W'(i);
            end
            if (slots[i].valid && slots[i].pix.x == in_pix.x && slots[i].pix.y == in_pix.y) begin
                dup_hit = 1'b1;
            end
            if (slots[i].valid && slots[i].pix.x == exp_x && slots[i].pix.y == exp_y) begin
                match_found = 1'b1;
                match_idx   = SLOT_W'(i);
            end
        end
    end

    assign out_of_range = (32'(in_pix.x) >= W_LIM) || (32'(in_pix.y) >= H_LIM);
    assign drop         = out_of_range || dup_hit;
    assign wr           = xfer && !drop && free_found;
    assign load         = match_found && (!out_valid || out_ready);

    always_comb begin
        occ_next = occupancy;
        if (wr && !load) begin
            occ_next = occupancy + 1'b1;
        end else if (!wr && load) begin
            occ_next = occupancy - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                slots[i] <= '0;
            end
            exp_x      <= '0;
            exp_y      <= '0;
            ptr        <= '0;
            stall_d    <= 1'b0;
            out_valid  <= 1'b0;
            out_colour <= '0;
            out_sof    <= 1'b0;
            out_eol    <= 1'b0;
            occupancy  <= '0;
            full       <= 1'b0;
            dup_drop   <= 1'b0;
            deadlock   <= 1'b0;
        end else begin
            if (xfer) begin
                ptr <= (grant_idx == PTR_W'(N_CH - 1)) ? '0 : grant_idx + 1'b1;
            end
            dup_drop <= xfer && drop;

            if (wr) begin
                slots[free_idx].valid <= 1'b1;
                slots[free_idx].pix   <= in_pix;
            end

            if (load) begin
                slots[match_idx].valid <= 1'b0;
                out_valid  <= 1'b1;
                out_colour <= slots[match_idx].pix.colour;
                out_sof    <= (exp_x == '0) && (exp_y == '0);
                out_eol    <= (exp_x == X_LAST);
                if (exp_x == X_LAST) begin
                    exp_x <= '0;
                    exp_y <= (exp_y == Y_LAST) ? '0 : exp_y + 1'b1;
                end else begin
                    exp_x <= exp_x + 1'b1;
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            occupancy <= occ_next;
            full      <= (occ_next == OCC_W'(DEPTH));

            // stall_d remembers that the previous cycle was also full with no match.
            if (full && !match_found) begin
                stall_d <= 1'b1;
                if (stall_d) begin
                    deadlock <= 1'b1;
                end
            end else begin
                stall_d <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pixel_reorder_buffer.sv
module tb_pixel_reorder_buffer;

    localparam int N_CH  = 4;
    localparam int DEPTH = 4;
    localparam int CW    = 24;
    localparam int XW    = 10;
    localparam int IMG_W = 4;
    localparam int IMG_H = 2;
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic                 clk = 1'b0;
    logic                 reset;
    logic [N_CH-1:0]      in_valid;
    logic [N_CH-1:0]      in_ready;
    logic [N_CH*CW-1:0]   in_colour;
    logic [N_CH*XW-1:0]   in_x;
    logic [N_CH*XW-1:0]   in_y;
    logic                 out_valid;
    logic                 out_ready;
    logic [CW-1:0]        out_colour;
    logic                 out_sof;
    logic                 out_eol;
    logic [OCC_W-1:0]     occupancy;
    logic                 full;
    logic                 dup_drop;
    logic                 deadlock;

    pixel_reorder_buffer #(
        .N_CH     (N_CH),
        .DEPTH    (DEPTH),
        .COLOUR_W (CW),
        .COORD_W  (XW),
        .IMG_W    (IMG_W),
        .IMG_H    (IMG_H)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_colour  (in_colour),
        .in_x       (in_x),
        .in_y       (in_y),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_colour (out_colour),
        .out_sof    (out_sof),
        .out_eol    (out_eol),
        .occupancy  (occupancy),
        .full       (full),
        .dup_drop   (dup_drop),
        .deadlock   (deadlock)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [CW-1:0] colour;
        logic          sof;
        logic          eol;
    } exp_t;

    exp_t expq[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   dup_cnt = 0;
    int   occ_peak = 0;
    int   first_valid_cyc = -1;
    int   last_acc_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: pops the scoreboard on every output handshake.
    always @(negedge clk) begin
        if (!reset) begin
            if (dup_drop) dup_cnt++;
            if (int'(occupancy) > occ_peak) occ_peak = int'(occupancy);
            if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (out_valid && out_ready) begin
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output actual=%0h required=none", out_colour);
                end else begin
                    mon_e = expq.pop_front();
                    check("out_pixel", 64'({out_colour, out_sof, out_eol}), 64'(mon_e));
                end
            end
        end
    end

    task automatic set_ch(input int ch, input int x, input int y, input int col);
        in_x[ch*XW +: XW]      = XW'(x);
        in_y[ch*XW +: XW]      = XW'(y);
        in_colour[ch*CW +: CW] = CW'(col);
    endtask

    task automatic push(input int ch, input int x, input int y, input int col);
        logic acc;
        acc = 1'b0;
        set_ch(ch, x, y, col);
        in_valid[ch] = 1'b1;
        for (int n = 0; n < 50 && !acc; n++) begin
            @(negedge clk);
            if (in_ready[ch]) begin
                acc = 1'b1;
                last_acc_cyc = cyc;
            end
        end
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL push_timeout actual=not_accepted required=accepted x=%0d y=%0d", x, y);
        end
        @(posedge clk);
        #1 in_valid[ch] = 1'b0;
    endtask

    task automatic do_reset();
        in_valid  = '0;
        out_ready = 1'b1;
        reset     = 1'b1;
        @(posedge clk);
        #1;
        check("reset_outputs",
              64'({out_valid, out_colour, out_sof, out_eol, occupancy, full, dup_drop, deadlock}), 64'd0);
        expq.delete();
        @(posedge clk);
        #1 reset = 1'b0;
        dup_cnt = 0;
        occ_peak = 0;
        first_valid_cyc = -1;
    endtask

    task automatic wait_drain();
        for (int n = 0; n < 100 && expq.size() != 0; n++) @(negedge clk);
        check("drain_remaining", 64'(expq.size()), 64'd0);
    endtask

    int acc0;
    logic [N_CH-1:0] g;
    logic [7:0] order [4];
    int ocount;

    initial begin
        in_valid  = '0;
        in_colour = '0;
        in_x      = '0;
        in_y      = '0;
        out_ready = 1'b1;
        reset     = 1'b1;
        repeat (2) @(posedge clk);

        // In-order single channel, full 4x2 frame.
        do_reset();
        for (int y = 0; y < IMG_H; y++) begin
            for (int x = 0; x < IMG_W; x++) begin
                int k;
                k = y * IMG_W + x + 1;
                expq.push_back('{colour: CW'(k), sof: (k == 1), eol: (x == IMG_W - 1)});
                push(0, x, y, k);
                if (k == 1) acc0 = last_acc_cyc;
            end
        end
        wait_drain();
        check("first_valid_latency", 64'(first_valid_cyc - acc0), 64'd2);

        // Reverse order, all channels at once: channel i carries (3-i,0).
        do_reset();
        for (int x = 0; x < 4; x++)
            expq.push_back('{colour: CW'('hA0 + x), sof: (x == 0), eol: (x == 3)});
        for (int i = 0; i < N_CH; i++) set_ch(i, 3 - i, 0, 'hA0 + 3 - i);
        in_valid = '1;
        ocount = 0;
        for (int n = 0; n < 20 && in_valid != '0; n++) begin
            @(negedge clk);
            g = in_ready & in_valid;
            check("one_grant_per_cycle", 64'($countones(g)), 64'd1);
            for (int i = 0; i < N_CH; i++)
                if (g[i] && ocount < 4) begin
                    order[ocount] = 8'(i);
                    ocount++;
                end
            @(posedge clk);
            #1 in_valid = in_valid & ~g;
        end
        in_valid = '0;
        wait_drain();
        check("grant_order", 64'({order[0], order[1], order[2], order[3]}), 64'h00010203);
        check("occupancy_peak", 64'(occ_peak), 64'd4);

        // Back-pressure: output stalled while six pixels are offered.
        do_reset();
        out_ready = 1'b0;
        for (int k = 0; k < 6; k++)
            expq.push_back('{colour: CW'('hB0 + k), sof: (k == 0), eol: ((k % 4) == 3)});
        for (int k = 0; k < 5; k++) push(0, k % 4, k / 4, 'hB0 + k);
        @(negedge clk);
        check("full_after_fill", 64'(full), 64'd1);
        #1;
        set_ch(0, 1, 1, 'hB5);
        in_valid[0] = 1'b1;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            check("blocked_ready", 64'(in_ready[0]), 64'd0);
            check("held_output", 64'({out_valid, out_colour, out_sof}), 64'({1'b1, 24'hB0, 1'b1}));
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        begin
            logic acc;
            acc = 1'b0;
            for (int n = 0; n < 50 && !acc; n++) begin
                @(negedge clk);
                if (in_ready[0]) acc = 1'b1;
            end
            check("sixth_accepted", 64'(acc), 64'd1);
            @(posedge clk);
            #1 in_valid[0] = 1'b0;
        end
        wait_drain();

        // Filtering: duplicate and out-of-range pixels are dropped.
        do_reset();
        push(0, 2, 0, 'hC2);
        push(0, 2, 0, 'hC3);
        push(0, 640, 0, 'hC4);
        repeat (3) @(negedge clk);
        check("dup_drop_pulses", 64'(dup_cnt), 64'd2);
        check("filter_occupancy", 64'(occupancy), 64'd1);

        // Deadlock: buffer full, (0,0) never arrives.
        do_reset();
        push(0, 1, 0, 'hD1);
        push(0, 2, 0, 'hD2);
        push(0, 3, 0, 'hD3);
        push(0, 0, 1, 'hD4);
        @(negedge clk);
        check("deadlock_full", 64'(full), 64'd1);
        check("deadlock_cycle1", 64'(deadlock), 64'd0);
        @(negedge clk);
        check("deadlock_cycle2", 64'(deadlock), 64'd0);
        @(negedge clk);
        check("deadlock_set", 64'(deadlock), 64'd1);
        repeat (5) @(negedge clk);
        check("deadlock_sticky", 64'(deadlock), 64'd1);

        // Reset mid-frame after three pixels have been emitted.
        do_reset();
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++)
            expq.push_back('{colour: CW'('hE0 + k), sof: (k == 0), eol: 1'b0});
        for (int k = 0; k < 4; k++) push(0, k, 0, 'hE0 + k);
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("midframe_reset_outputs",
              64'({out_valid, out_colour, out_sof, out_eol, occupancy, full, dup_drop, deadlock}), 64'd0);
        check("emitted_before_reset", 64'(expq.size()), 64'd0);
        reset = 1'b0;
        out_ready = 1'b1;
        expq.push_back('{colour: CW'('hF0), sof: 1'b1, eol: 1'b0});
        push(0, 0, 0, 'hF0);
        wait_drain();

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
